syncfifo_n: RTL and testbench

//  Parametrised single-clock FIFO, N entries deep, successor to the 1-deep/2-register FIFO synchronizer.

---
 rtl/cdc_pkg.sv | 13 +
 rtl/syncfifo_ram.sv | 29 ++
 rtl/syncfifo_n.sv | 111 +++++++++++
 tb/tb_syncfifo_n.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the FIFO/synchronizer family.
//   ptr_w()      : width of a wrap-bit pointer (and of an occupancy count)
//                  for a power-of-2 depth, i.e. $clog2(depth)+1.
//   rd_status_e  : debug view of the read side (EMPTY_S / AVAIL_S).
package cdc_pkg;

  function automatic int unsigned ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {EMPTY_S, AVAIL_S} rd_status_e;

endpackage

// File: rtl/syncfifo_ram.sv
// DEPTH-entry storage for syncfifo_n: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write payload
//   raddr : read address
//   rdata : mem[raddr], combinational
module syncfifo_ram #(
  parameter type         dat_t = logic [7:0],
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  dat_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output dat_t                     rdata
);

  dat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syncfifo_n.sv
// Single-clock first-word-fall-through FIFO, DEPTH entries (power of 2).
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   clr                 : synchronous flush; overrides same-cycle wput/rget
//   wdata, wput, wrdy   : write side
//   rdata, rget, rrdy   : read side; rdata shows the head word while rrdy
//   count               : occupancy 0..DEPTH
//   almost_full/empty   : count >= AF_THR / count <= AE_THR
//   ovf, udf            : sticky error flags, cleared by reset or clr
//
// Handshake: wrdy/rrdy depend only on registered state, never on wput/rget.
// A transfer happens on a rising edge where request and ready are both 1
// (we = wput & wrdy, re = rget & rrdy). A request while not ready is dropped
// and recorded in the sticky ovf/udf flag.
module syncfifo_n
  import cdc_pkg::*;
#(
  parameter type         dat_t  = logic [7:0],
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AF_THR = DEPTH - 2,
  parameter int unsigned AE_THR = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  dat_t                      wdata,
  input  logic                      wput,
  output logic                      wrdy,
  output dat_t                      rdata,
  input  logic                      rget,
  output logic                      rrdy,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      ovf,
  output logic                      udf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  // Parameter sanity, checked at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("syncfifo_n: DEPTH must be a power of 2 and >= 2");
  end
  if ((AF_THR < 1) || (AF_THR > DEPTH)) begin : g_bad_af
    $error("syncfifo_n: AF_THR must be in 1..DEPTH");
  end
  if (AE_THR > DEPTH - 1) begin : g_bad_ae
    $error("syncfifo_n: AE_THR must be in 0..DEPTH-1");
  end

  logic [PW-1:0] wptr, rptr;
  logic          full, empty;
  logic          we, re;
  rd_status_e    rd_status;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_status = empty ? EMPTY_S : AVAIL_S;

  assign wrdy = ~full;
  assign rrdy = (rd_status == AVAIL_S);
  assign we   = wput & wrdy;
  assign re   = rget & rrdy;

  assign almost_full  = (count >= PW'(AF_THR));
  assign almost_empty = (count <= PW'(AE_THR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (we) wptr <= wptr + PW'(1);
      if (re) rptr <= rptr + PW'(1);
      case ({we, re})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
      ovf <= ovf | (wput & ~wrdy);
      udf <= udf | (rget & ~rrdy);
    end
  end

  // A flush must leave memory untouched, so the flush cycle's write is masked.
  syncfifo_ram #(
    .dat_t (dat_t),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we & ~clr),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_syncfifo_n.sv
module tb_syncfifo_n;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] wdata;
  logic       wput;
  logic       wrdy;
  logic [7:0] rdata;
  logic       rget;
  logic       rrdy;
  logic [3:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       ovf;
  logic       udf;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp;

  syncfifo_n #(
    .dat_t  (logic [7:0]),
    .DEPTH  (8),
    .AF_THR (6),
    .AE_THR (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wdata        (wdata),
    .wput         (wput),
    .wrdy         (wrdy),
    .rdata        (rdata),
    .rget         (rget),
    .rrdy         (rrdy),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf),
    .udf          (udf)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Driver helpers: inputs change and outputs are sampled 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    wput  = 1'b1;
    wdata = d;
    exp_q.push_back(d);
    tick();
    wput  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wrdy"},  32'(wrdy), 32'd1);
    check({tag, "_rrdy"},  32'(rrdy), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ae"},    32'(almost_empty), 32'd1);
    check({tag, "_af"},    32'(almost_full), 32'd0);
    check({tag, "_ovf"},   32'(ovf), 32'd0);
    check({tag, "_udf"},   32'(udf), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    wput  = 1'b0;
    rget  = 1'b0;
    wdata = '0;

    // Reset
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    // 1. Fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      check("fill_af_pre", 32'(almost_full), 32'(i >= 6));
      wput  = 1'b1;
      wdata = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_rdata", 32'(rdata), 32'h10);
      check("fill_rrdy",  32'(rrdy), 32'd1);
    end
    wput = 1'b0;
    check("full_wrdy", 32'(wrdy), 32'd0);
    check("full_af",   32'(almost_full), 32'd1);
    check("full_ae",   32'(almost_empty), 32'd0);

    // 2. Drain
    rget = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      check("drain_rdata", 32'(rdata), 32'(exp));
      check("drain_ae",    32'(almost_empty), 32'((8 - i) <= 1));
      tick();
    end
    rget = 1'b0;
    check("drain_rrdy",  32'(rrdy), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_ae_end", 32'(almost_empty), 32'd1);
    check("drain_udf",   32'(udf), 32'd0);

    // 3. Wrap: prefill 3, then 20 cycles of simultaneous write+read
    push_word(8'h20);
    push_word(8'h21);
    push_word(8'h22);
    check("wrap_prefill", 32'(count), 32'd3);
    wput = 1'b1;
    rget = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wdata = 8'h30 + 8'(i);
      exp = exp_q.pop_front();
      check("wrap_rdata", 32'(rdata), 32'(exp));
      exp_q.push_back(8'h30 + 8'(i));
      tick();
      check("wrap_count", 32'(count), 32'd3);
    end
    wput = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      check("wrap_tail", 32'(rdata), 32'(exp));
      tick();
    end
    rget = 1'b0;
    check("wrap_empty", 32'(count), 32'd0);
    check("wrap_ovf",   32'(ovf), 32'd0);

    // 4a. Full with wput & rget: only the read is accepted
    for (int i = 0; i < 8; i++) push_word(8'h50 + 8'(i));
    check("coll_full_count", 32'(count), 32'd8);
    wput  = 1'b1;
    rget  = 1'b1;
    wdata = 8'hEE;
    exp = exp_q.pop_front();
    check("coll_full_head", 32'(rdata), 32'(exp));
    tick();
    wput = 1'b0;
    rget = 1'b0;
    check("coll_full_count7", 32'(count), 32'd7);
    check("coll_full_ovf",    32'(ovf), 32'd1);
    check("coll_full_udf",    32'(udf), 32'd0);
    check("coll_full_next",   32'(rdata), 32'h51);
    check("coll_full_wrdy",   32'(wrdy), 32'd1);

    // clr to reach empty; also clears ovf
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    check("clr1_count", 32'(count), 32'd0);
    check("clr1_ovf",   32'(ovf), 32'd0);

    // 4b. Empty with wput & rget: only the write is accepted
    wput  = 1'b1;
    rget  = 1'b1;
    wdata = 8'h66;
    tick();
    wput = 1'b0;
    rget = 1'b0;
    check("coll_empty_count", 32'(count), 32'd1);
    check("coll_empty_udf",   32'(udf), 32'd1);
    check("coll_empty_ovf",   32'(ovf), 32'd0);
    check("coll_empty_rrdy",  32'(rrdy), 32'd1);
    check("coll_empty_rdata", 32'(rdata), 32'h66);

    // 5. Flush with 5 entries, clr together with wput & rget
    for (int i = 0; i < 4; i++) push_word(8'h70 + 8'(i));
    check("flush_pre_count", 32'(count), 32'd5);
    clr   = 1'b1;
    wput  = 1'b1;
    rget  = 1'b1;
    wdata = 8'h99;
    tick();
    clr  = 1'b0;
    wput = 1'b0;
    rget = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_rrdy",  32'(rrdy), 32'd0);
    check("flush_wrdy",  32'(wrdy), 32'd1);
    check("flush_ovf",   32'(ovf), 32'd0);
    check("flush_udf",   32'(udf), 32'd0);
    push_word(8'hAA);
    exp = exp_q.pop_front();
    check("flush_readback", 32'(rdata), 32'(exp));
    check("flush_rb_count", 32'(count), 32'd1);
    rget = 1'b1;
    tick();
    rget = 1'b0;
    check("flush_rb_drain", 32'(count), 32'd0);

    // 6. Asynchronous reset during an active burst at count 4
    for (int i = 0; i < 4; i++) push_word(8'h80 + 8'(i));
    wput = 1'b1;
    rget = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wdata = 8'h84 + 8'(i);
      tick();
      check("burst_count", 32'(count), 32'd4);
    end
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    wput = 1'b0;
    rget = 1'b0;
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_release");
    push_word(8'h55);
    exp = exp_q.pop_front();
    check("post_rst_rdata", 32'(rdata), 32'(exp));
    check("post_rst_count", 32'(count), 32'd1);
    rget = 1'b1;
    tick();
    rget = 1'b0;
    check("post_rst_rrdy",  32'(rrdy), 32'd0);
    check("post_rst_empty", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
